if_prefetch: RTL
================

# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue, successor to the single-register IF stage of the MIPS R2000 pipeline. It issues sequential word fetches to a fixed-latency instruction memory, buffers returned {pc, instruction} pairs in a DEPTH-entry FIFO, and presents the head entry to decode. Branch and exception redirects flush the queue and discard in-flight responses. Sits between instruction memory and the ID stage.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- ADDR_W, 32, PC width
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h8000_0080, exception redirect target
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- hold_pc  in  1  stop issuing new fetches; queue contents kept
- hold_if  in  1  decode stall; head entry not consumed
- br  in  1  branch redirect request
- pc_branch  in  ADDR_W  branch target, sampled when br=1
- except  in  1  exception redirect, priority over br
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address (word aligned)
- imem_rdata  in  DATA_W  instruction, valid the cycle after imem_req
- pc_out  out  ADDR_W  PC of head entry
- inst_out  out  DATA_W  instruction of head entry
- valid_out  out  1  head entry valid
- level  out  $clog2(DEPTH+1)  entries currently queued

## Operation
- State: fetch_pc, inflight flag (one outstanding response max per cycle), FIFO wr/rd pointers, count.
- Redirect cycle (except=1 or br=1, rst=1): at edge count←0, pointers←0, inflight←0 (response arriving next cycle discarded), fetch_pc←EXC_VECTOR if except else pc_branch. imem_req=0 in this cycle. Pop ignored.
- pop = valid_out & !hold_if & !redirect.
- Issue: imem_req = rst & !hold_pc & !redirect & (count + inflight − pop < DEPTH). imem_addr = fetch_pc. On issue fetch_pc←fetch_pc+4 (wraps 32'hFFFF_FFFC → 0); inflight←1 else 0.
- Response: if inflight=1 and no redirect this cycle, push {pc of issued request, imem_rdata}. Issued PC held in a register alongside inflight.
- Simultaneous push and pop: both performed, count unchanged. Credit rule guarantees push never finds queue full.
- Empty: valid_out=0, inst_out=32'h0000_0000 (NOP), pc_out=0.
- hold_pc and hold_if independent: hold_if alone fills queue then stops issue by credit; hold_pc alone drains queue.

## Timing
- Reset (rst=0 at an edge): fetch_pc←RESET_PC, count/pointers/inflight←0. During reset: imem_req=0, valid_out=0, inst_out=0, pc_out=0, level=0.
- Reset mid-operation discards queue and in-flight response identically to a redirect.
- First rst=1 cycle C0: imem_req=1, addr RESET_PC; C1 rdata returned and pushed; C2 valid_out=1.
- Request-to-valid_out latency 2 cycles; redirect-to-valid_out 3 cycles (redirect C0, request C1, push C2, valid C3).
- Steady state with hold_if=0: one instruction per cycle.
- Outputs pc_out/inst_out/valid_out/level are register-driven; imem_req/imem_addr combinational from state and br/except/hold_pc/hold_if.

## Structure
- Shared package mips_pkg: RESET_PC, EXC_VECTOR defaults, NOP constant, typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: DEPTH-entry show-ahead FIFO with push, pop, flush, count; if_prefetch holds fetch_pc, inflight and credit logic.

## Test plan
- Reset release, hold_if=0, rdata=addr-derived → valid_out high at C2, pc_out 0,4,8,… one per cycle, level ≤ 2.
- hold_if=1 from C2 → level reaches DEPTH=4, imem_req drops, head stays pc 0; release → pcs 0..12 then 16 with no gap or duplicate.
- br=1, pc_branch=32'h0000_0400 while queue holds 3 entries and a response is in flight → queue empties next cycle, in-flight word dropped, valid_out with pc_out 0x400 exactly 3 cycles after br.
- br=1 and except=1 same cycle → redirect to 32'h8000_0080; pc_branch ignored.
- fetch_pc=32'hFFFF_FFF8 → pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst=0 asserted mid-stream with queue full → next cycle valid_out=0, level=0, imem_req=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: reset/exception vectors, the NOP encoding
// and the {pc, inst} pair carried through the prefetch queue.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0080;

    // sll $0,$0,0 encodes as all zeros; shown to decode when the queue is empty
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO for fetched {pc, inst} pairs. The head entry, valid flag
// and count are held in registers so decode sees clean flop outputs; the
// next head is selected ahead of the edge, bypassing a push that lands
// directly at the new read position.
module fetch_fifo #(
    parameter int unsigned      DEPTH = 4,
    parameter int unsigned      WIDTH = 64,
    parameter logic [WIDTH-1:0] EMPTY = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] w_head_next;

    // Next-state pointers/count and the entry that will sit at the head
    always_comb begin
        w_pop        = i_pop & r_valid;
        w_rd_next    = r_rd + PTR_W'(w_pop);
        w_count_next = r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        // The slot being written this cycle is not in r_mem yet
        if (i_push && (w_rd_next == r_wr)) begin
            w_head_next = i_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Entry storage; stale slots are never read, so no reset is needed
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    // Pointers, occupancy and registered head; flush behaves like reset
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= EMPTY;
        end else begin
            r_wr    <= r_wr + PTR_W'(i_push);
            r_rd    <= w_rd_next;
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            r_head  <= (w_count_next != '0) ? w_head_next : EMPTY;
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with prefetch queue. Issues sequential word
// fetches to a one-cycle-latency instruction memory, keeps at most one
// response in flight, and only issues when the queue is guaranteed to have
// room for that response. Branch/exception redirects flush the queue and
// drop the in-flight word.
module if_prefetch
    import mips_pkg::*;
#(
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEFAULT)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_hold_pc,
    input  logic                        i_hold_if,
    input  logic                        i_br,
    input  logic [ADDR_W-1:0]           i_pc_branch,
    input  logic                        i_except,
    output logic                        o_imem_req,
    output logic [ADDR_W-1:0]           o_imem_addr,
    input  logic [DATA_W-1:0]           i_imem_rdata,
    output logic [ADDR_W-1:0]           o_pc_out,
    output logic [DATA_W-1:0]           o_inst_out,
    output logic                        o_valid_out,
    output logic [$clog2(DEPTH+1)-1:0]  o_level
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_issue_pc;
    logic               r_inflight;

    logic               w_redirect;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [CNT_W:0]     w_credit_use;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic               w_valid;
    logic [CNT_W-1:0]   w_count;

    // Redirect, pop/push qualification and the issue credit check
    always_comb begin
        w_redirect   = i_except | i_br;
        w_pop        = w_valid & ~i_hold_if & ~w_redirect;
        w_push       = i_rst & r_inflight & ~w_redirect;
        w_push_data  = {r_issue_pc, i_imem_rdata};
        // Slots committed after this cycle: queued + arriving - leaving
        w_credit_use = {1'b0, w_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
        w_issue      = i_rst & ~i_hold_pc & ~w_redirect
                     & (w_credit_use < (CNT_W + 1)'(DEPTH));
    end

    // Fetch PC, in-flight flag and the PC paired with the pending response
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc <= i_except ? EXC_VECTOR : i_pc_branch;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issue_pc <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .EMPTY ({ADDR_W'(0), DATA_W'(NOP)})
    ) u_fetch_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (w_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_count     (w_count)
    );

    assign o_imem_req  = w_issue;
    assign o_imem_addr = r_fetch_pc;
    assign o_pc_out    = w_head[ENTRY_W-1:DATA_W];
    assign o_inst_out  = w_head[DATA_W-1:0];
    assign o_valid_out = w_valid;
    assign o_level     = w_count;

endmodule
